regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_sb_scoreboard.sv | 96 +++++++++
 rtl/regfile_sb.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

    // Default geometry: a 32 x 32-bit integer register file.
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Register index at the default geometry.
    typedef logic [AW_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-writeback tracker: one pending bit per architectural register plus
// a running count of how many are set. Register 0 is hard-wired and can never
// become pending, so the count tops out at NREGS-1.
//
// Readiness contract: rd_ready[i] is a combinational flag with no handshake.
// When it is 1, the rd_data[i] presented in the same cycle is the value a
// consumer may use. When it is 0, the register still waits on an in-flight
// producer and rd_data[i] is stale.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    output logic [NRD-1:0]          rd_ready,
    output logic [CW-1:0]           pend_count
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [CW-1:0]    n_inc;
    logic [CW-1:0]    n_dec;
    logic [NRD-1:0]   wr_hit;

    // Decode this cycle's issue and writeback requests into per-register vectors.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en && (iss_addr != '0)) begin
            set_vec[iss_addr] = 1'b1;
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w] != '0)) begin
                clr_vec[wr_addr[w]] = 1'b1;
            end
        end
    end

    // Next pending state and the incremental count change. An issue beats a
    // writeback to the same register: the new producer keeps the bit set.
    always_comb begin
        pending_next = pending;
        n_inc        = '0;
        n_dec        = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (set_vec[r]) begin
                pending_next[r] = 1'b1;
                if (!pending[r]) begin
                    n_inc = n_inc + CW'(1);
                end
            end else if (clr_vec[r]) begin
                pending_next[r] = 1'b0;
                if (pending[r]) begin
                    n_dec = n_dec + CW'(1);
                end
            end
        end
    end

    // Pending bits and count; reset clears both immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_next;
            pend_count <= pend_count + n_inc - n_dec;
        end
    end

    // Operand readiness: x0, a non-pending register, or a same-cycle writeback
    // (which the data path bypasses) are all usable. Everything is ready in reset.
    always_comb begin
        wr_hit   = '0;
        rd_ready = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w] == rd_addr[i])) begin
                    wr_hit[i] = 1'b1;
                end
            end
            rd_ready[i] = rst || (rd_addr[i] == '0) || !pending[rd_addr[i]] || wr_hit[i];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with write-through bypass and a pending-writeback
// scoreboard. NREGS must be a power of two (>= 2) so every address decodes to
// a real register. Register 0 reads as zero and ignores writes and issues.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = $clog2(NREGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_ready,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [CW-1:0]            pend_count
);

    logic [XLEN-1:0] regs [NREGS];

    // Array update: ports applied in ascending order so the highest-index
    // port wins on an address collision. Entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    regs[wr_addr[w]] <= wr_data[w];
                end
            end
        end
    end

    // Combinational read with write-through bypass, same port priority as the
    // array update. Reset forces zero (the array is cleared anyway).
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rst && (rd_addr[i] != '0)) begin
                rd_data[i] = regs[rd_addr[i]];
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w] == rd_addr[i])) begin
                        rd_data[i] = wr_data[w];
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW),
        .CW    (CW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .pend_count (pend_count)
    );

endmodule
